note_correlator: RTL and testbench

NOTE_CORRELATOR -- requirements
Module: note_correlator

---
 rtl/note_correlator_pkg.sv | 58 +++++
 rtl/note_template_rom.sv | 28 ++
 rtl/note_correlator.sv | 132 +++++++++++++
 tb/tb_note_correlator.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_correlator_pkg.sv
// Shared constants, engine state encoding and the cosine lookup that builds
// the note templates.
//   N / WIN_LOG2 : correlation window length (64 samples)
//   SAMPLE_W     : signed audio sample width
//   TMPL_W       : signed template coefficient width
//   ACC_W        : MAC accumulator width (12 + 8 + 6 bits, cannot overflow)
//   OUT_W        : correlation magnitude width
//   NUM_NOTES    : number of valid templates
package note_correlator_pkg;
  localparam int WIN_LOG2  = 6;
  localparam int N         = 1 << WIN_LOG2;
  localparam int SAMPLE_W  = 12;
  localparam int TMPL_W    = 8;
  localparam int ACC_W     = 26;
  localparam int OUT_W     = 10;
  localparam int NUM_NOTES = 5;
  localparam int NOTE_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } eng_state_t;

  // round(127*cos(2*pi*j/64)) for j = 0..16 (first quarter wave)
  function automatic logic signed [TMPL_W-1:0] quarter(input logic [4:0] j);
    case (j)
      5'd0:    quarter = 8'sd127;
      5'd1:    quarter = 8'sd126;
      5'd2:    quarter = 8'sd125;
      5'd3:    quarter = 8'sd122;
      5'd4:    quarter = 8'sd117;
      5'd5:    quarter = 8'sd112;
      5'd6:    quarter = 8'sd106;
      5'd7:    quarter = 8'sd98;
      5'd8:    quarter = 8'sd90;
      5'd9:    quarter = 8'sd81;
      5'd10:   quarter = 8'sd71;
      5'd11:   quarter = 8'sd60;
      5'd12:   quarter = 8'sd49;
      5'd13:   quarter = 8'sd37;
      5'd14:   quarter = 8'sd25;
      5'd15:   quarter = 8'sd12;
      default: quarter = 8'sd0;
    endcase
  endfunction

  // Full 64-point cosine from the quarter table using quadrant symmetry:
  // Q0: T[r]  Q1: -T[16-r]  Q2: -T[r]  Q3: T[16-r]
  function automatic logic signed [TMPL_W-1:0] cos_q(input logic [5:0] ph);
    logic [4:0]               j;
    logic signed [TMPL_W-1:0] m;
    j = ph[4] ? (5'd16 - {1'b0, ph[3:0]}) : {1'b0, ph[3:0]};
    m = quarter(j);
    cos_q = (ph[5] ^ ph[4]) ? -m : m;
  endfunction
endpackage

// File: rtl/note_template_rom.sv
// Template ROM: NUM_NOTES signed 8-bit cosine templates, note n carrying n
// cycles per window (note 0 is the DC template, all +127). Registered read,
// one cycle latency. Notes >= NUM_NOTES read as zero.
//   clk   : read clock
//   note  : template select
//   index : sample index within the window
//   data  : template[note][index], valid the cycle after the address
module note_template_rom
  import note_correlator_pkg::*;
#(
  parameter int IDX_W = WIN_LOG2
) (
  input  logic                     clk,
  input  logic [NOTE_W-1:0]        note,
  input  logic [IDX_W-1:0]         index,
  output logic signed [TMPL_W-1:0] data
);
  logic [5:0]               phase;
  logic signed [TMPL_W-1:0] rom_val;

  always_comb begin
    // phase on a 64-point circle, independent of the window length
    phase   = 6'(((32'(note) * 32'(index)) << 6) >> IDX_W);
    rom_val = (note < NOTE_W'(NUM_NOTES)) ? cos_q(phase) : '0;
  end

  always_ff @(posedge clk) data <= rom_val;
endmodule

// File: rtl/note_correlator.sv
// Windowed correlator: ping-pong sample buffers, one filling while the MAC
// engine correlates the other against the selected note template.
//   clk, rst          : clock, async active-high reset
//   sample            : signed audio sample
//   sample_valid      : one-cycle accept strobe
//   note_sel          : template select, latched at MAC start
//   correlation       : saturated |acc| >> OUT_SHIFT, held between pulses
//   correlation_valid : one-cycle pulse per correlated window
//   overrun           : sticky, a completed window was dropped
module note_correlator
  import note_correlator_pkg::*;
#(
  parameter int WIN_LOG2  = 6,
  parameter int OUT_SHIFT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic                       sample_valid,
  input  logic [NOTE_W-1:0]          note_sel,
  output logic [OUT_W-1:0]           correlation,
  output logic                       correlation_valid,
  output logic                       overrun
);
  localparam int NW       = 1 << WIN_LOG2;
  localparam int AW       = SAMPLE_W + TMPL_W + WIN_LOG2;
  localparam int CORR_MAX = (1 << OUT_W) - 1;

  logic signed [SAMPLE_W-1:0] buf0 [NW];
  logic signed [SAMPLE_W-1:0] buf1 [NW];

  logic                        fill_sel;
  logic [WIN_LOG2-1:0]         wr_idx;
  logic                        start_q;
  logic                        wrap, busy, swap;
  eng_state_t                  state, state_nx;
  logic [WIN_LOG2-1:0]         rd_idx;
  logic [NOTE_W-1:0]           note_q;
  logic                        mac_vld;
  logic signed [SAMPLE_W-1:0]  smp_q;
  logic signed [TMPL_W-1:0]    tmpl_q;
  logic signed [SAMPLE_W+TMPL_W-1:0] prod;
  logic signed [AW-1:0]        acc;
  logic [AW-1:0]               mag, scaled;
  logic [OUT_W-1:0]            corr_nx;

  // A window completing while the engine still owns the other buffer (or is
  // about to start on it) is dropped; the fill buffer simply refills from 0.
  assign wrap = sample_valid && (wr_idx == '1);
  assign busy = (state != ST_IDLE) || start_q;
  assign swap = wrap && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_sel <= 1'b0;
      wr_idx   <= '0;
      start_q  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      start_q <= swap;
      if (sample_valid) wr_idx <= wr_idx + 1'b1;
      if (swap) fill_sel <= ~fill_sel;
      if (wrap && busy) overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sample_valid) begin
      if (fill_sel) buf1[wr_idx] <= sample;
      else          buf0[wr_idx] <= sample;
    end
  end

  // Engine reads the buffer not being filled; registered to line up with the
  // template ROM's one-cycle read.
  always_ff @(posedge clk) smp_q <= fill_sel ? buf0[rd_idx] : buf1[rd_idx];

  note_template_rom #(.IDX_W(WIN_LOG2)) u_rom (
    .clk   (clk),
    .note  (note_q),
    .index (rd_idx),
    .data  (tmpl_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start_q) state_nx = ST_MAC;
      ST_MAC:    if (rd_idx == '1) state_nx = ST_DRAIN;
      ST_DRAIN:  state_nx = ST_FINISH;
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign prod = smp_q * tmpl_q;

  always_comb begin
    mag    = acc[AW-1] ? AW'(-acc) : AW'(acc);
    scaled = mag >> OUT_SHIFT;
    if (note_q >= NOTE_W'(NUM_NOTES))  corr_nx = '0;
    else if (scaled > AW'(CORR_MAX))   corr_nx = OUT_W'(CORR_MAX);
    else                               corr_nx = scaled[OUT_W-1:0];
  end

  // Address issued in MAC cycle k, operands registered one edge later,
  // accumulated the edge after that; the last product lands as FINISH starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      rd_idx            <= '0;
      note_q            <= '0;
      mac_vld           <= 1'b0;
      acc               <= '0;
      correlation       <= '0;
      correlation_valid <= 1'b0;
    end else begin
      state             <= state_nx;
      mac_vld           <= (state == ST_MAC);
      correlation_valid <= (state == ST_FINISH);
      if (state == ST_IDLE && start_q) begin
        note_q <= note_sel;
        rd_idx <= '0;
        acc    <= '0;
      end else if (state == ST_MAC) begin
        rd_idx <= rd_idx + 1'b1;
      end
      if (mac_vld) acc <= acc + AW'(prod);
      if (state == ST_FINISH) correlation <= corr_nx;
    end
  end
endmodule

// File: tb/tb_note_correlator.sv
module tb_note_correlator;
  typedef int win_t[64];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [11:0] sample = '0;
  logic              sample_valid = 1'b0;
  logic [2:0]        note_sel = '0;
  logic [9:0]        correlation, corr2;
  logic              correlation_valid, cv2;
  logic              overrun, ov2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  note_correlator dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .note_sel(note_sel), .correlation(correlation),
    .correlation_valid(correlation_valid), .overrun(overrun)
  );

  // Smaller shift so full-scale input drives the output into saturation.
  note_correlator #(.OUT_SHIFT(12)) dut_sat (
    .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
    .note_sel(note_sel), .correlation(corr2),
    .correlation_valid(cv2), .overrun(ov2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int tmpl_ref(input int n, input int i);
    real v;
    if (n >= 5) return 0;
    v = 127.0 * $cos(2.0 * 3.14159265358979 * n * i / 64.0);
    return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
  endfunction

  function automatic int corr_ref(input win_t s, input int n, input int sh);
    longint a = 0;
    longint m;
    for (int i = 0; i < 64; i++) a += longint'(s[i]) * tmpl_ref(n, i);
    m = (a < 0) ? -a : a;
    m = m >>> sh;
    if (n >= 5) return 0;
    return (m > 1023) ? 1023 : int'(m);
  endfunction

  task automatic send_window(input win_t s, input int note, output int e0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      sample = 12'(s[i]); sample_valid = 1'b1; note_sel = 3'(note);
    end
    @(posedge clk); #1;
    e0 = cyc;
    @(negedge clk) sample_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int e0, output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (correlation_valid) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (correlation_valid) cnt++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    if (correlation !== 10'd0) begin errors++; $display("FAIL reset_corr got=%0d want=0", correlation); end
    checks++;
    if (correlation_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", correlation_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    checks++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_dc_full_scale;
    win_t s; int e0, lat, cnt, ev;
    foreach (s[i]) s[i] = 2047;
    exp_q.push_back(507);
    send_window(s, 0, e0);
    wait_pulse(e0, lat);
    if (lat !== 67) begin errors++; $display("FAIL dc_latency got=%0d want=67", lat); end
    checks++;
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (int'(correlation) !== ev) begin errors++; $display("FAIL dc_corr got=%0d want=%0d", correlation, ev); end
    checks++;
    if (cv2 !== 1'b1 || corr2 !== 10'd1023) begin
      errors++; $display("FAIL dc_saturate valid=%b got=%0d want=1023", cv2, corr2);
    end
    checks++;
    count_pulses(20, cnt);
    if (cnt !== 0 || correlation !== 10'(ev)) begin
      errors++; $display("FAIL dc_single_pulse extra=%0d held=%0d want 0/%0d", cnt, correlation, ev);
    end
    checks++;
  endtask

  task automatic test_negative;
    win_t s; int e0, lat, ev;
    foreach (s[i]) s[i] = -2048;
    exp_q.push_back(508);
    send_window(s, 0, e0);
    wait_pulse(e0, lat);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (lat !== 67 || int'(correlation) !== ev) begin
      errors++; $display("FAIL neg_corr lat=%0d got=%0d want 67/%0d", lat, correlation, ev);
    end
    checks++;
  endtask

  task automatic test_tone;
    win_t s; int e0, lat, ev, peak;
    foreach (s[i]) s[i] = 16 * tmpl_ref(2, i);
    exp_q.push_back(corr_ref(s, 2, 15));
    send_window(s, 2, e0);
    wait_pulse(e0, lat);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (lat !== 67 || int'(correlation) !== ev) begin
      errors++; $display("FAIL tone_peak lat=%0d got=%0d want 67/%0d", lat, correlation, ev);
    end
    checks++;
    peak = int'(correlation);
    exp_q.push_back(corr_ref(s, 0, 15));
    send_window(s, 0, e0);
    wait_pulse(e0, lat);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (lat !== 67 || int'(correlation) !== ev) begin
      errors++; $display("FAIL tone_orth lat=%0d got=%0d want 67/%0d", lat, correlation, ev);
    end
    checks++;
    if (int'(correlation) * 20 >= peak || peak < 200) begin
      errors++; $display("FAIL tone_ratio orth=%0d peak=%0d want orth<5%% of peak", correlation, peak);
    end
    checks++;
  endtask

  task automatic test_invalid_note;
    win_t s; int e0, cnt;
    foreach (s[i]) s[i] = 2047;
    exp_q.push_back(0);
    send_window(s, 6, e0);
    count_pulses(90, cnt);
    if (cnt !== 1) begin errors++; $display("FAIL bad_note_pulses got=%0d want=1", cnt); end
    checks++;
    if (correlation !== 10'(exp_q.pop_front())) begin
      errors++; $display("FAIL bad_note_corr got=%0d want=0", correlation);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    win_t a, b, c; int e0, lat, cnt, ev;
    foreach (a[i]) begin
      a[i] = 16 * tmpl_ref(3, i);
      b[i] = (i * 37) % 1000 - 500;
      c[i] = 16 * tmpl_ref(1, i);
    end
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_pre_overrun got=%b want=0", overrun); end
    checks++;
    exp_q.push_back(corr_ref(a, 3, 15));
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      sample = 12'((i < 64) ? a[i] : b[i - 64]); sample_valid = 1'b1; note_sel = 3'd3;
    end
    @(negedge clk) sample_valid = 1'b0;
    count_pulses(100, cnt);
    if (cnt !== 1) begin errors++; $display("FAIL b2b_pulses got=%0d want=1", cnt); end
    checks++;
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (int'(correlation) !== ev) begin errors++; $display("FAIL b2b_first got=%0d want=%0d", correlation, ev); end
    checks++;
    if (overrun !== 1'b1 || ov2 !== 1'b1) begin
      errors++; $display("FAIL b2b_overrun got=%b/%b want=1", overrun, ov2);
    end
    checks++;
    exp_q.push_back(corr_ref(c, 1, 15));
    send_window(c, 1, e0);
    wait_pulse(e0, lat);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (lat !== 67 || int'(correlation) !== ev) begin
      errors++; $display("FAIL b2b_restart lat=%0d got=%0d want 67/%0d", lat, correlation, ev);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_sticky got=%b want=1", overrun); end
    checks++;
  endtask

  task automatic test_reset_mid_mac;
    win_t s; int e0, lat, cnt, ev;
    foreach (s[i]) s[i] = 2047;
    send_window(s, 0, e0);
    repeat (31) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (correlation !== 10'd0 || correlation_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mac_outputs corr=%0d valid=%b ovr=%b want 0/0/0",
                         correlation, correlation_valid, overrun);
    end
    checks++;
    @(negedge clk) rst = 1'b0;
    count_pulses(100, cnt);
    if (cnt !== 0) begin errors++; $display("FAIL rst_mac_no_pulse got=%0d want=0", cnt); end
    checks++;
    foreach (s[i]) s[i] = 1000 - 30 * i;
    exp_q.push_back(corr_ref(s, 0, 15));
    send_window(s, 0, e0);
    wait_pulse(e0, lat);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    if (lat !== 67 || int'(correlation) !== ev) begin
      errors++; $display("FAIL rst_mac_recover lat=%0d got=%0d want 67/%0d", lat, correlation, ev);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_dc_full_scale();
    test_negative();
    test_tone();
    test_invalid_note();
    test_back_to_back();
    test_reset_mid_mac();
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
